// File: rtl/rnbip_pkg.sv
// Shared definitions for the 3-stage core pipeline sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the sequencer state encoding, the NOP opcode loaded by bubbles and
// the opcode field positions used by the read/execute stages.
package rnbip_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    STEP   = 2'd3
  } seq_state_e;

  localparam logic [7:0] NOP_OC = 8'h00;

  // Opcode fields: RS = register select, AF = ALU function.
  localparam int RS_LSB = 0;
  localparam int RS_MSB = 2;
  localparam int AF_LSB = 4;
  localparam int AF_MSB = 7;

  function automatic logic [2:0] oc_rs(input logic [7:0] oc);
    return oc[RS_MSB:RS_LSB];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count visible one edge after inc/clr.
// Backpressure: none; holds at all-ones, clr wins over inc.
//
// Ports: clk, rst (async active-high), inc, clr, cnt[W-1:0].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stall, branch flush, debug halt/step, perf counters.
// Latency: strobes are combinational in the current cycle; state/counters update on the next edge.
// Backpressure: hazard stalls fetch/read for one cycle; halt drains DRAIN_CYCLES edges before halt_ack.
//
// Ports: clk, rst; l_pc, e_ld/e_dst_r0/e_dst_rn/e_rs (execute), r_src_r0/r_src_rn/r_rs (read);
// dbg_halt_req, dbg_step, cnt_clr; outputs pc_en, hold_r, bubble_r, bubble_e, halt_ack,
// state, stall_cnt, flush_cnt.
module pipe_hazard_ctrl
  import rnbip_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             l_pc,
  input  logic             e_ld,
  input  logic             e_dst_r0,
  input  logic             e_dst_rn,
  input  logic [2:0]       e_rs,
  input  logic             r_src_r0,
  input  logic             r_src_rn,
  input  logic [2:0]       r_rs,
  input  logic             dbg_halt_req,
  input  logic             dbg_step,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             hold_r,
  output logic             bubble_r,
  output logic             bubble_e,
  output logic             halt_ack,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  seq_state_e    state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [DW-1:0] drain_inc;
  logic          haz;
  logic          stall_inc;
  logic          flush_inc;

  // Load-use: the execute instruction's DM load lands too late for the
  // read-stage consumer of the same register.
  assign haz = e_ld & ((e_dst_r0 & r_src_r0) |
                       (e_dst_rn & r_src_rn & (e_rs == r_rs)));

  assign drain_inc = drain_q + DW'(1);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      RUN: begin
        if (dbg_halt_req) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (!dbg_halt_req) begin
          state_d = RUN;
          drain_d = '0;
        end else if (l_pc) begin
          // Squashed instructions refill the pipe, so the drain restarts.
          drain_d = '0;
        end else if (!haz) begin
          // A stall cycle moves nothing forward, so the count freezes.
          if (drain_inc == DW'(DRAIN_CYCLES)) begin
            state_d = HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_inc;
          end
        end
      end
      HALTED: begin
        if (!dbg_halt_req) begin
          state_d = RUN;
        end else if (dbg_step) begin
          state_d = STEP;
        end
      end
      STEP: begin
        drain_d = '0;
        state_d = dbg_halt_req ? DRAIN : RUN;
      end
      default: begin
        state_d = RUN;
        drain_d = '0;
      end
    endcase
  end

  // Strobe priority: reset > flush > hazard > per-state defaults.
  always_comb begin
    pc_en    = 1'b0;
    hold_r   = 1'b0;
    bubble_r = 1'b0;
    bubble_e = 1'b0;
    halt_ack = 1'b0;
    unique case (state_q)
      RUN:     pc_en = 1'b1;
      DRAIN:   bubble_r = 1'b1;
      HALTED: begin
        bubble_r = 1'b1;
        bubble_e = 1'b1;
        halt_ack = 1'b1;
      end
      STEP:    pc_en = 1'b1;
      default: pc_en = 1'b0;
    endcase
    if (haz) begin
      pc_en    = 1'b0;
      hold_r   = 1'b1;
      bubble_r = 1'b0;
      bubble_e = 1'b1;
    end
    if (l_pc) begin
      // The PC load path wins inside the PC, so no increment here.
      pc_en    = 1'b0;
      hold_r   = 1'b0;
      bubble_r = 1'b1;
      bubble_e = 1'b1;
    end
    if (rst) begin
      pc_en    = 1'b0;
      hold_r   = 1'b0;
      bubble_r = 1'b1;
      bubble_e = 1'b1;
      halt_ack = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  assign state = state_q;

  assign stall_inc = haz & ~l_pc & (state_q != HALTED);
  assign flush_inc = l_pc & (state_q != HALTED);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .clr (cnt_clr),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .clr (cnt_clr),
    .cnt (flush_cnt)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 3-stage core: fetch (PC/PM), read (OC_R/OR1/NPC) and execute (OC_E/OR2, CCG2).
- Replaces the hard-tied PC increment enable. Generates the stall, bubble and flush strobes for load-use hazards and taken branches.
- Runs a debug halt/single-step handshake that drains the pipeline before acknowledging.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- CNT_W, 16, width of stall_cnt and flush_cnt.
- DRAIN_CYCLES, 2, clock edges in DRAIN before the pipeline is empty (one per pipeline register stage).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- l_pc  in  1  taken branch/jump/call/return in execute (CCG2 L_PC).
- e_ld  in  1  execute-stage instruction loads a register from DM (RD with L_R0 or L_RN).
- e_dst_r0  in  1  execute instruction writes R0.
- e_dst_rn  in  1  execute instruction writes RN.
- e_rs  in  3  execute RN select (OC_E[2:0]).
- r_src_r0  in  1  read-stage instruction consumes R0.
- r_src_rn  in  1  read-stage instruction consumes RN.
- r_rs  in  3  read-stage RN select (OC_R[2:0]).
- dbg_halt_req  in  1  level halt request.
- dbg_step  in  1  one-cycle pulse; honoured only in HALTED.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_en  out  1  PC increment enable (I_PC).
- hold_r  out  1  OC_R, OR1 and NPC keep their value.
- bubble_r  out  1  OC_R loads NOP (8'h00), OR1 loads 0.
- bubble_e  out  1  OC_E loads NOP, OR2 loads 0.
- halt_ack  out  1  pipeline empty and frozen.
- state  out  2  RUN=0, DRAIN=1, HALTED=2, STEP=3.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  branch flush events.

Behaviour:
- Reset (async, while rst=1):
  - state=RUN, drain counter=0, both counters=0.
  - Outputs forced: pc_en=0, hold_r=0, bubble_r=1, bubble_e=1, halt_ack=0.
- Hazard, combinational:
  - haz = e_ld & ((e_dst_r0 & r_src_r0) | (e_dst_rn & r_src_rn & e_rs==r_rs)).
- Strobe priority each cycle: flush > haz > state defaults.
- Flush (l_pc=1, any state):
  - pc_en=0; the PC load path takes priority inside the PC.
  - bubble_r=1, bubble_e=1, hold_r=0.
  - flush_cnt+1. The two wrong-path instructions are squashed on that edge.
- haz=1 without l_pc:
  - pc_en=0, hold_r=1, bubble_e=1, bubble_r=0; stall_cnt+1.
  - Lasts exactly one cycle, because the next edge places NOP in execute and clears e_ld.
  - hold_r overrides bubble_r.
- RUN:
  - pc_en=1, others 0.
  - dbg_halt_req=1 -> DRAIN, drain counter=0.
- DRAIN:
  - pc_en=0, bubble_r=1. The unfetched PC instruction is refetched on resume.
  - Drain counter +1 per edge, except on haz cycles (frozen) and l_pc cycles (reset to 0).
  - Counter reaches DRAIN_CYCLES -> HALTED.
  - dbg_halt_req falls during DRAIN -> RUN next edge.
- HALTED:
  - pc_en=0, bubble_r=1, bubble_e=1, halt_ack=1.
  - dbg_halt_req=0 -> RUN; halt_ack drops at that edge.
  - Else dbg_step=1 -> STEP.
- STEP:
  - One cycle with pc_en=1 and all bubbles 0, so exactly one instruction enters OC_R.
  - Then -> DRAIN with the counter at 0. The instruction executes during the drain, then the core re-halts.
  - If dbg_halt_req=0 in STEP -> RUN.
- Counters:
  - Saturate at all-ones.
  - cnt_clr has priority over increment.
  - Not incremented in HALTED.
- A flush or haz in the same cycle as a state transition still follows the priority above; the state transition proceeds unchanged.

Decomposition:
- Shared package rnbip_pkg holds:
  - state enum/localparams (RUN, DRAIN, HALTED, STEP);
  - NOP_OC = 8'h00;
  - the opcode field positions RS [2:0] and AF [7:4].
- Sub-module sat_counter (parameter W; inc, clr). Instantiate it twice.

Test Plan:
- Reset mid-run: assert rst for 3 cycles while state=DRAIN -> immediately state=0, pc_en=0, bubble_r=bubble_e=1, counters 0. After release, pc_en=1 next cycle.
- Load-use stall: e_ld=1, e_dst_rn=1, e_rs=3, r_src_rn=1, r_rs=3 for one cycle -> pc_en=0, hold_r=1, bubble_e=1 that cycle only; stall_cnt=1.
- No false stall: same case but r_rs=4 -> pc_en=1, stall_cnt stays 0.
- Flush overrides hazard: l_pc=1 together with the hazard condition -> bubble_r=bubble_e=1, hold_r=0; flush_cnt=1, stall_cnt=0.
- Halt/step: dbg_halt_req=1 in RUN -> DRAIN for 2 edges -> HALTED, halt_ack=1. Then a dbg_step pulse -> exactly one cycle with pc_en=1 (PC +1), then DRAIN, HALTED again after 2 edges. Release dbg_halt_req -> RUN, halt_ack=0.
- Saturation/clear: force 65536 stall cycles with CNT_W=16 -> stall_cnt holds 16'hFFFF. cnt_clr together with a stall cycle -> 0.
